lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/defs_pkg.sv | 39 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_mem.sv | 129 ++++++++++++
 tb/tb_lsu_mem.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defs_pkg.sv
// Shared LSU definitions: op encodings, access sizes, FSM state type and alignment helper.
package defs_pkg;

   localparam int unsigned LsuOpWidth = 4;

   // op[3] = store, op[2] = zero-extend load, op[1:0] = log2 of access size in bytes
   localparam logic [LsuOpWidth-1:0] OpLb  = 4'b0000;
   localparam logic [LsuOpWidth-1:0] OpLh  = 4'b0001;
   localparam logic [LsuOpWidth-1:0] OpLw  = 4'b0010;
   localparam logic [LsuOpWidth-1:0] OpLbu = 4'b0100;
   localparam logic [LsuOpWidth-1:0] OpLhu = 4'b0101;
   localparam logic [LsuOpWidth-1:0] OpSb  = 4'b1000;
   localparam logic [LsuOpWidth-1:0] OpSh  = 4'b1001;
   localparam logic [LsuOpWidth-1:0] OpSw  = 4'b1010;

   localparam int unsigned OpStoreBit = 3;
   localparam int unsigned OpUnsBit   = 2;

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait
   } lsu_state_e;

   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr);
      logic mis;
      case (size)
         SzByte:  mis = 1'b0;
         SzHalf:  mis = addr[0];
         default: mis = (addr != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
   import defs_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rdata_i[{addr_i, 3'b000} +: 8];
   assign rd_half = rdata_i[{addr_i[1], 4'b0000} +: 16];

   always_comb begin
      be_o        = 4'b1111;
      wdata_o     = store_data_i;
      load_data_o = rdata_i;
      unique case (size_i)
         SzByte: begin
            be_o        = 4'b0001 << addr_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = {{24{rd_byte[7] & ~uns_i}}, rd_byte};
         end
         SzHalf: begin
            be_o        = 4'b0011 << {addr_i[1], 1'b0};
            wdata_o     = {2{store_data_i[15:0]}};
            load_data_o = {{16{rd_half[15] & ~uns_i}}, rd_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: one outstanding data-memory access, stalls upstream meanwhile.
module lsu_mem
   import defs_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_m,
   input  logic [LsuOpWidth-1:0] lsu_op_m,
   input  logic [31:0]           alu_res_m,
   input  logic [31:0]           store_data_m,
   input  logic [4:0]            rd_addr_m,
   input  logic                  rd_en_m,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic [31:0]           dmem_addr,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [31:0]           dmem_rdata,
   output logic                  stall_m,
   output logic                  rd_en_w,
   output logic [4:0]            rd_addr_w,
   output logic [31:0]           rd_data_w,
   output logic                  misaligned_w
);

   lsu_state_e            state_q, state_d;
   logic [LsuOpWidth-1:0] op_q;
   logic [31:0]           addr_q, sdata_q;
   logic [4:0]            rd_addr_q;
   logic                  rd_en_q;
   logic                  capture;

   logic                  rd_en_w_d, misaligned_w_d;
   logic [4:0]            rd_addr_w_d;
   logic [31:0]           rd_data_w_d;
   logic [31:0]           load_data;

   lsu_align u_align (
      .size_i      (op_q[1:0]),
      .uns_i       (op_q[OpUnsBit]),
      .addr_i      (addr_q[1:0]),
      .store_data_i(sdata_q),
      .rdata_i     (dmem_rdata),
      .be_o        (dmem_be),
      .wdata_o     (dmem_wdata),
      .load_data_o (load_data)
   );

   assign dmem_addr = {addr_q[31:2], 2'b00};
   assign dmem_we   = op_q[OpStoreBit];

   always_comb begin
      state_d        = state_q;
      capture        = 1'b0;
      stall_m        = 1'b0;
      dmem_req_valid = 1'b0;
      rd_en_w_d      = 1'b0;
      rd_addr_w_d    = rd_addr_w;
      rd_data_w_d    = rd_data_w;
      misaligned_w_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!lsu_m) begin
               rd_data_w_d = alu_res_m;
               rd_addr_w_d = rd_addr_m;
               rd_en_w_d   = rd_en_m && (rd_addr_m != 5'd0);
            end else if (lsu_misaligned(lsu_op_m[1:0], alu_res_m[1:0])) begin
               misaligned_w_d = 1'b1;
            end else begin
               capture = 1'b1;
               stall_m = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            dmem_req_valid = 1'b1;
            // A store retires on the handshake; a load still waits for its response.
            if (dmem_req_ready && op_q[OpStoreBit]) begin
               state_d = StIdle;
            end else begin
               stall_m = 1'b1;
               if (dmem_req_ready) state_d = StWait;
            end
         end
         StWait: begin
            if (dmem_rsp_valid) begin
               rd_data_w_d = load_data;
               rd_addr_w_d = rd_addr_q;
               rd_en_w_d   = rd_en_q && (rd_addr_q != 5'd0);
               state_d     = StIdle;
            end else begin
               stall_m = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         op_q         <= '0;
         addr_q       <= '0;
         sdata_q      <= '0;
         rd_addr_q    <= '0;
         rd_en_q      <= 1'b0;
         rd_en_w      <= 1'b0;
         rd_addr_w    <= '0;
         rd_data_w    <= '0;
         misaligned_w <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_en_w      <= rd_en_w_d;
         rd_addr_w    <= rd_addr_w_d;
         rd_data_w    <= rd_data_w_d;
         misaligned_w <= misaligned_w_d;
         if (capture) begin
            op_q      <= lsu_op_m;
            addr_q    <= alu_res_m;
            sdata_q   <= store_data_m;
            rd_addr_q <= rd_addr_m;
            rd_en_q   <= rd_en_m;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized bench for lsu_mem: transaction-level model, per-cycle compare, literal pins.
module tb_lsu_mem;
   import defs_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_m;
   logic [3:0]  lsu_op_m;
   logic [31:0] alu_res_m, store_data_m;
   logic [4:0]  rd_addr_m;
   logic        rd_en_m;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall_m, rd_en_w, misaligned_w;
   logic [4:0]  rd_addr_w;
   logic [31:0] rd_data_w;

   lsu_mem dut (
      .clk           (clk),
      .rst           (rst),
      .lsu_m         (lsu_m),
      .lsu_op_m      (lsu_op_m),
      .alu_res_m     (alu_res_m),
      .store_data_m  (store_data_m),
      .rd_addr_m     (rd_addr_m),
      .rd_en_m       (rd_en_m),
      .dmem_req_valid(dmem_req_valid),
      .dmem_req_ready(dmem_req_ready),
      .dmem_addr     (dmem_addr),
      .dmem_we       (dmem_we),
      .dmem_be       (dmem_be),
      .dmem_wdata    (dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rdata    (dmem_rdata),
      .stall_m       (stall_m),
      .rd_en_w       (rd_en_w),
      .rd_addr_w     (rd_addr_w),
      .rd_data_w     (rd_data_w),
      .misaligned_w  (misaligned_w)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Expectations for the current cycle, published by the driver.
   bit          chk_on = 1'b0;
   bit          exp_stall, exp_req, exp_we;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_be;
   bit          wb_en, wb_mis, wb_chk;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int          stall_seen = 0;
   int          req_seen = 0;
   logic [3:0]  seen_be;
   logic [31:0] seen_wdata;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int m_size(input logic [3:0] op);
      if (op == OpLb || op == OpLbu || op == OpSb) return 1;
      if (op == OpLh || op == OpLhu || op == OpSh) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
      int off = int'(addr[1:0]);
      int sz = m_size(op);
      logic [3:0] be = '0;
      for (int l = 0; l < 4; l++) be[l] = (l >= off) && (l < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] data);
      int sz = m_size(op);
      logic [31:0] wd;
      for (int l = 0; l < 4; l++) wd[8*l +: 8] = data[8*(l % sz) +: 8];
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                          input logic [31:0] word);
      logic [31:0] sh = word >> (8 * int'(addr[1:0]));
      if (op == OpLb)  return {{24{sh[7]}}, sh[7:0]};
      if (op == OpLbu) return {24'd0, sh[7:0]};
      if (op == OpLh)  return {{16{sh[15]}}, sh[15:0]};
      if (op == OpLhu) return {16'd0, sh[15:0]};
      return word;
   endfunction

   function automatic logic [3:0] pick_op(input int k);
      case (k)
         0: return OpLb;
         1: return OpLh;
         2: return OpLw;
         3: return OpLbu;
         4: return OpLhu;
         5: return OpSb;
         6: return OpSh;
         default: return OpSw;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("stall_m", 32'(stall_m), 32'(exp_stall));
         check("dmem_req_valid", 32'(dmem_req_valid), 32'(exp_req));
         if (exp_req) begin
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_we", 32'(dmem_we), 32'(exp_we));
            if (exp_we) begin
               check("dmem_be", 32'(dmem_be), 32'(exp_be));
               check("dmem_wdata", dmem_wdata, exp_wdata);
            end
         end
         check("rd_en_w", 32'(rd_en_w), 32'(wb_en));
         check("misaligned_w", 32'(misaligned_w), 32'(wb_mis));
         if (wb_chk) begin
            check("rd_addr_w", 32'(rd_addr_w), 32'(wb_addr));
            check("rd_data_w", rd_data_w, wb_data);
         end
      end
      if (stall_m) stall_seen++;
      if (dmem_req_valid) begin
         req_seen++;
         seen_be    = dmem_be;
         seen_wdata = dmem_wdata;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after the instruction retires.
   task automatic run_instr(input logic [3:0] op, input bit mem, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] rd, input bit rden,
                            input int dr, input int ds, input logic [31:0] rword);
      bit is_store, mis;
      int n;
      is_store = mem && (op == OpSb || op == OpSh || op == OpSw);
      mis      = mem && ((int'(addr[1:0]) % m_size(op)) != 0);
      if (!mem || mis) n = 0;
      else if (is_store) n = 1 + dr;
      else n = 2 + dr + ds;
      lsu_m = mem; lsu_op_m = op; alu_res_m = addr; store_data_m = sdata;
      rd_addr_m = rd; rd_en_m = rden;
      exp_addr  = {addr[31:2], 2'b00};
      exp_we    = is_store;
      exp_be    = m_be(op, addr);
      exp_wdata = m_wdata(op, sdata);
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin
            lsu_m = 1'($urandom); lsu_op_m = 4'($urandom); alu_res_m = $urandom;
            store_data_m = $urandom; rd_addr_m = 5'($urandom); rd_en_m = 1'($urandom);
            wb_en = 1'b0; wb_mis = 1'b0; wb_chk = 1'b0;
         end
         exp_stall = (c < n);
         exp_req   = (n > 0) && (c >= 1) && (c <= 1 + dr);
         dmem_req_ready = exp_req ? (c == 1 + dr) : 1'($urandom);
         if (n > 0 && !is_store && c >= 2 + dr) dmem_rsp_valid = (c == n);
         else dmem_rsp_valid = 1'($urandom);
         dmem_rdata = (n > 0 && !is_store && c == n) ? rword : $urandom;
         @(posedge clk); #1;
      end
      if (!mem) begin
         wb_en = rden && (rd != 0); wb_addr = rd; wb_data = addr; wb_chk = 1'b1; wb_mis = 1'b0;
      end else if (mis) begin
         wb_en = 1'b0; wb_mis = 1'b1; wb_chk = 1'b0;
      end else if (is_store) begin
         wb_en = 1'b0; wb_mis = 1'b0; wb_chk = 1'b0;
      end else begin
         wb_en = rden && (rd != 0); wb_addr = rd; wb_data = m_load(op, addr, rword);
         wb_chk = 1'b1; wb_mis = 1'b0;
      end
      exp_stall = 1'b0; exp_req = 1'b0;
      lsu_m = 1'b0; rd_en_m = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
   endtask

   task automatic set_zero_wb();
      exp_stall = 1'b0; exp_req = 1'b0;
      wb_en = 1'b0; wb_mis = 1'b0; wb_chk = 1'b1; wb_addr = '0; wb_data = '0;
   endtask

   int          s0, r0;
   logic [3:0]  rop;
   bit          rmem;
   logic [31:0] ra;

   initial begin
      rst = 1'b1; lsu_m = 1'b0; lsu_op_m = '0; alu_res_m = '0; store_data_m = '0;
      rd_addr_m = '0; rd_en_m = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      set_zero_wb();
      chk_on = 1'b1;
      rst = 1'b0;

      // ALU passthrough
      s0 = stall_seen;
      run_instr(4'h0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
      check("alu_rd_en", 32'(rd_en_w), 32'd1);
      check("alu_rd_addr", 32'(rd_addr_w), 32'd5);
      check("alu_rd_data", rd_data_w, 32'h0000_1234);
      check("alu_stall_cycles", 32'(stall_seen - s0), 32'd0);

      // LB from top byte, immediate ready/response
      s0 = stall_seen;
      run_instr(OpLb, 1'b1, 32'h103, 32'h0, 5'd1, 1'b1, 0, 0, 32'h80FF_FFFF);
      check("lb_rd_data", rd_data_w, 32'hFFFF_FF80);
      check("lb_stall_cycles", 32'(stall_seen - s0), 32'd2);

      // SH to upper half, ready delayed 3 cycles
      s0 = stall_seen; r0 = req_seen;
      run_instr(OpSh, 1'b1, 32'h102, 32'h0000_ABCD, 5'd2, 1'b0, 3, 0, 32'h0);
      check("sh_be", 32'(seen_be), 32'h0000_000C);
      check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
      check("sh_stall_cycles", 32'(stall_seen - s0), 32'd4);
      check("sh_req_cycles", 32'(req_seen - r0), 32'd4);

      // Misaligned LW
      s0 = stall_seen; r0 = req_seen;
      run_instr(OpLw, 1'b1, 32'h101, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0);
      check("lw_mis_pulse", 32'(misaligned_w), 32'd1);
      check("lw_mis_rd_en", 32'(rd_en_w), 32'd0);
      check("lw_mis_req_cycles", 32'(req_seen - r0), 32'd0);
      check("lw_mis_stall_cycles", 32'(stall_seen - s0), 32'd0);

      // LBU into x0 then x3
      run_instr(OpLbu, 1'b1, 32'h100, 32'h0, 5'd0, 1'b1, 1, 1, 32'h0000_00FF);
      check("lbu_x0_rd_en", 32'(rd_en_w), 32'd0);
      run_instr(OpLbu, 1'b1, 32'h100, 32'h0, 5'd3, 1'b1, 0, 2, 32'h0000_00FF);
      check("lbu_x3_rd_en", 32'(rd_en_w), 32'd1);
      check("lbu_x3_rd_data", rd_data_w, 32'h0000_00FF);

      // Reset in WAIT, then a late response
      chk_on = 1'b0;
      lsu_m = 1'b1; lsu_op_m = OpLw; alu_res_m = 32'h100; rd_addr_m = 5'd7; rd_en_m = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0; rst = 1'b1;
      lsu_m = 1'b0; rd_en_m = 1'b0; alu_res_m = '0; rd_addr_m = '0;
      #1 check("wait_stall", 32'(stall_m), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      #1;
      check("rst_rd_en", 32'(rd_en_w), 32'd0);
      check("rst_rd_data", rd_data_w, 32'd0);
      check("rst_rd_addr", 32'(rd_addr_w), 32'd0);
      check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
      check("rst_stall", 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      #1;
      check("late_rsp_rd_en", 32'(rd_en_w), 32'd0);
      check("late_rsp_rd_data", rd_data_w, 32'd0);

      // Reset in REQ abandons the request
      lsu_m = 1'b1; lsu_op_m = OpSw; alu_res_m = 32'h104; store_data_m = 32'h1357_9BDF;
      @(posedge clk); #1;
      lsu_m = 1'b0; alu_res_m = '0;
      #1 check("req_valid_before_rst", 32'(dmem_req_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("req_abandoned", 32'(dmem_req_valid), 32'd0);
      set_zero_wb();
      chk_on = 1'b1;

      for (int i = 0; i < 300; i++) begin
         rop  = pick_op(int'($urandom_range(0, 7)));
         rmem = ($urandom_range(0, 9) < 7);
         ra   = rmem ? 32'h100 + $urandom_range(0, 63) : $urandom;
         if (rmem && $urandom_range(0, 1) == 1) ra = ra & ~32'(m_size(rop) - 1);
         run_instr(rop, rmem, ra, $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
